// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle between a producer/consumer (master) and alu_seq (slave).
// Carries no state of its own; the master drives operands and out_ready, the slave drives result and flags.
interface alu_seq_if #(
  parameter int N = 10
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         carry_in;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         n_flag;
  logic         c_flag;
  logic         v_flag;
  logic         z_flag;
  logic         busy;

  modport master (
    output in_valid, a, b, carry_in, op, out_ready,
    input  in_ready, out_valid, result, n_flag, c_flag, v_flag, z_flag, busy
  );

  modport slave (
    input  in_valid, a, b, carry_in, op, out_ready,
    output in_ready, out_valid, result, n_flag, c_flag, v_flag, z_flag, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle 16-op ALU, 1-bit/cycle shifter; ALU_SEQ_MUL_EN adds an N-cycle shift-add multiplier.
// Latency: 1 cycle for ops 0-9,15; min(k,N)+1 for shifts/rotate; N+1 for multiply.
// Backpressure: result held in DONE until out_ready; no new accept until the result is taken.
module alu_seq #(
  parameter int N = 10
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  work_q, work_d;
  logic [N-1:0]  res_q, res_d;
  logic [3:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] stp_q, stp_d;
  logic          sc_q, sc_d;
  logic          n_q, n_d, c_q, c_d, v_q, v_d, z_q, z_d;
`ifdef ALU_SEQ_MUL_EN
  logic [2*N-1:0] acc_q, acc_d, mc_q, mc_d, acc_n;
`endif

  logic          accept;
  logic [CW-1:0] k_ext, k_sat, k_mod;
  logic [N-1:0]  add_y, sc_res;
  logic [N:0]    sum;
  logic          add_ci, sc_c, sc_v, is_shift;
  logic [N-1:0]  wn;
  logic          cn;

  assign accept   = bus.in_valid && (state_q == IDLE);
  assign k_ext    = CW'(bus.b[SW-1:0]);
  assign k_sat    = (k_ext >= CW'(N)) ? CW'(N) : k_ext;
  assign k_mod    = (k_ext >= CW'(N)) ? k_ext - CW'(N) : k_ext;
  assign is_shift = (bus.op == 4'd10) || (bus.op == 4'd11) || (bus.op == 4'd12) || (bus.op == 4'd14);

  // Single-cycle datapath: all arithmetic is one N+1-bit adder with a selected second operand.
  always_comb begin
    add_y  = bus.b;
    add_ci = 1'b0;
    case (bus.op)
      4'd1:    begin add_y = ~bus.b;     add_ci = 1'b1;         end
      4'd2:    begin add_y = N'(1);                             end
      4'd3:    begin add_y = ~(N'(1));   add_ci = 1'b1;         end
      4'd8:    begin add_y = bus.b;      add_ci = bus.carry_in; end
      4'd9:    begin add_y = ~bus.b;     add_ci = bus.carry_in; end
      default: ;
    endcase
    sum = {1'b0, bus.a} + {1'b0, add_y} + {{N{1'b0}}, add_ci};

    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (bus.op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9: begin
        sc_res = sum[N-1:0];
        sc_c   = sum[N];
        sc_v   = (bus.a[N-1] == add_y[N-1]) && (sum[N-1] != bus.a[N-1]);
      end
      4'd4:    sc_res = bus.a & bus.b;
      4'd5:    sc_res = bus.a | bus.b;
      4'd6:    sc_res = bus.a ^ bus.b;
      4'd7:    sc_res = ~bus.a;
      4'd15:   sc_res = bus.b;
      4'd10, 4'd11, 4'd12, 4'd14: sc_res = bus.a;
      default: sc_res = '0;
    endcase
  end

  // One shift/rotate step; once the rotate steps are spent the word just idles until the cycle count expires.
  always_comb begin
    wn = work_q;
    cn = sc_q;
    if (stp_q != '0) begin
      case (op_q)
        4'd10:   begin cn = work_q[N-1]; wn = {work_q[N-2:0], 1'b0};        end
        4'd11:   begin cn = work_q[0];   wn = {1'b0, work_q[N-1:1]};        end
        4'd12:   begin cn = work_q[0];   wn = {work_q[N-1], work_q[N-1:1]}; end
        default: begin cn = work_q[N-1]; wn = {work_q[N-2:0], work_q[N-1]}; end
      endcase
    end
  end

`ifdef ALU_SEQ_MUL_EN
  assign acc_n = work_q[0] ? acc_q + mc_q : acc_q;
`endif

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    res_d   = res_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    stp_d   = stp_q;
    sc_d    = sc_q;
    n_d     = n_q;
    c_d     = c_q;
    v_d     = v_q;
    z_d     = z_q;
`ifdef ALU_SEQ_MUL_EN
    acc_d   = acc_q;
    mc_d    = mc_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = bus.op;
          if (is_shift && (k_sat != '0)) begin
            state_d = SHIFT;
            work_d  = bus.a;
            cnt_d   = k_sat;
            stp_d   = (bus.op == 4'd14) ? k_mod : k_sat;
            sc_d    = 1'b0;
`ifdef ALU_SEQ_MUL_EN
          end else if (bus.op == 4'd13) begin
            state_d = MUL;
            work_d  = bus.b;
            mc_d    = {{N{1'b0}}, bus.a};
            acc_d   = '0;
            cnt_d   = CW'(N);
`endif
          end else begin
            state_d = DONE;
            res_d   = sc_res;
            c_d     = sc_c;
            v_d     = sc_v;
            n_d     = sc_res[N-1];
            z_d     = (sc_res == '0);
          end
        end
      end
      SHIFT: begin
        work_d = wn;
        sc_d   = cn;
        cnt_d  = cnt_q - CW'(1);
        if (stp_q != '0) stp_d = stp_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          res_d   = wn;
          c_d     = cn;
          v_d     = 1'b0;
          n_d     = wn[N-1];
          z_d     = (wn == '0);
        end
      end
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        acc_d  = acc_n;
        mc_d   = mc_q << 1;
        work_d = work_q >> 1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          res_d   = acc_n[N-1:0];
          c_d     = |acc_n[2*N-1:N];
          v_d     = |acc_n[2*N-1:N];
          n_d     = acc_n[N-1];
          z_d     = (acc_n[N-1:0] == '0);
        end
      end
`endif
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      res_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      stp_q   <= '0;
      sc_q    <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_q   <= '0;
      mc_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      res_q   <= res_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      stp_q   <= stp_d;
      sc_q    <= sc_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q   <= acc_d;
      mc_q    <= mc_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = res_q;
  assign bus.n_flag    = n_q;
  assign bus.c_flag    = c_q;
  assign bus.v_flag    = v_q;
  assign bus.z_flag    = z_q;
endmodule
